// File: rtl/ledg_fx_pkg.sv
// Shared constants for the LEDG effects driver: register addresses,
// CTRL bit positions and register reset values.
package ledg_fx_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_MASK   = 2'd3;

    localparam int CTRL_FX_EN    = 0;
    localparam int CTRL_BLINK_EN = 1;

    // Both are sliced down to the configured register widths at the point of use.
    localparam logic [31:0] DUTY_RST   = 32'hFFFF_FFFF;
    localparam logic [31:0] PERIOD_RST = 32'h0000_0000;

endpackage

// File: rtl/ledg_fx_driver_if.sv
// Avalon-MM slave port of the LEDG effects driver (zero wait state, word addressed).
interface ledg_fx_driver_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/ledg_fx_blink_timer.sv
// Blink half-period timer. phase idles high, so lanes only go dark once a
// non-zero half-period has fully elapsed.
module ledg_fx_blink_timer #(
    parameter int BLINK_BITS = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BLINK_BITS-1:0] period,
    input  logic                  period_wr,
    output logic                  phase
);

    logic [BLINK_BITS-1:0] blink_cnt;

    // Count 0..period-1 and toggle phase on wrap; a PERIOD write restarts
    // the half-period from scratch and takes priority over a wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (period_wr || (period == '0)) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == period - BLINK_BITS'(1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
    end

endmodule

// File: rtl/ledg_fx_driver.sv
// Green-LED output stage: registers the PIO pattern onto the LEDG pins and,
// when enabled, gates it with a global PWM brightness and a per-lane blink.
// Out of reset it is a plain 1-cycle register.
module ledg_fx_driver
    import ledg_fx_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24
) (
    input  logic              clk,
    input  logic              reset,
    ledg_fx_driver_if.slave   avs,
    input  logic [WIDTH-1:0]  led_in,
    output logic [WIDTH-1:0]  led_out
);

    logic [1:0]            ctrl_q;
    logic [PWM_BITS-1:0]   duty_q;
    logic [BLINK_BITS-1:0] period_q;
    logic [WIDTH-1:0]      mask_q;
    logic [PWM_BITS-1:0]   pwm_cnt;

    logic             wr_en;
    logic             period_wr;
    logic             pwm_on;
    logic             phase;
    logic [WIDTH-1:0] blink_gate;

    assign wr_en     = avs.chipselect && !avs.write_n;
    assign period_wr = wr_en && (avs.address == ADDR_PERIOD);

    // Configuration registers; unused writedata bits are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            duty_q   <= DUTY_RST[PWM_BITS-1:0];
            period_q <= PERIOD_RST[BLINK_BITS-1:0];
            mask_q   <= '0;
        end else if (wr_en) begin
            case (avs.address)
                ADDR_CTRL:   ctrl_q   <= avs.writedata[1:0];
                ADDR_DUTY:   duty_q   <= avs.writedata[PWM_BITS-1:0];
                ADDR_PERIOD: period_q <= avs.writedata[BLINK_BITS-1:0];
                default:     mask_q   <= avs.writedata[WIDTH-1:0];
            endcase
        end
    end

    // Zero-wait read mux, zero-extended to the bus width.
    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_CTRL:   avs.readdata[1:0]            = ctrl_q;
            ADDR_DUTY:   avs.readdata[PWM_BITS-1:0]   = duty_q;
            ADDR_PERIOD: avs.readdata[BLINK_BITS-1:0] = period_q;
            default:     avs.readdata[WIDTH-1:0]      = mask_q;
        endcase
    end

    // PWM counter free-runs even with effects off so enabling needs no resync.
    always_ff @(posedge clk) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    // Full-scale DUTY must mean always on, which a plain compare cannot reach.
    assign pwm_on = (duty_q == '1) || (pwm_cnt < duty_q);

    ledg_fx_blink_timer #(
        .BLINK_BITS (BLINK_BITS)
    ) u_blink_timer (
        .clk       (clk),
        .reset     (reset),
        .period    (period_q),
        .period_wr (period_wr),
        .phase     (phase)
    );

    assign blink_gate = ~{WIDTH{ctrl_q[CTRL_BLINK_EN]}} | ~mask_q | {WIDTH{phase}};

    // Registered pin drive: transparent when effects are off.
    always_ff @(posedge clk) begin
        if (reset)                    led_out <= '0;
        else if (!ctrl_q[CTRL_FX_EN]) led_out <= led_in;
        else                          led_out <= led_in & {WIDTH{pwm_on}} & blink_gate;
    end

endmodule

// File: tb/tb_ledg_fx_driver.sv
// Directed bench for ledg_fx_driver: register table, transparency table,
// then hand-written PWM, blink, PERIOD-restart and reset sequences.
module tb_ledg_fx_driver;
    import ledg_fx_pkg::*;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } reg_vec_t;

    typedef struct {
        logic [8:0] din;
        logic [8:0] exp_out;
    } led_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] led_in;
    logic [8:0] led_out;
    logic [31:0] rd;

    int n_cmp = 0;
    int n_bad = 0;

    reg_vec_t regs [8];
    led_vec_t leds [5];

    ledg_fx_driver_if bus ();

    ledg_fx_driver #(
        .WIDTH      (9),
        .PWM_BITS   (8),
        .BLINK_BITS (24)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .avs     (bus.slave),
        .led_in  (led_in),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Leaves the write strobe removed 1ns after the write edge.
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic check_reset_regs(input string tag);
        read_reg(ADDR_CTRL, rd);   check({tag, "_ctrl"},   rd, 32'h0);
        read_reg(ADDR_DUTY, rd);   check({tag, "_duty"},   rd, 32'hFF);
        read_reg(ADDR_PERIOD, rd); check({tag, "_period"}, rd, 32'h0);
        read_reg(ADDR_MASK, rd);   check({tag, "_mask"},   rd, 32'h0);
    endtask

    initial begin
        int on_cnt;
        int other_cnt;
        logic [8:0] prev;
        logic [8:0] exp_blink;

        regs[0] = '{ADDR_CTRL,   32'hFFFF_FFFF, 32'h0000_0003};
        regs[1] = '{ADDR_DUTY,   32'h1234_5678, 32'h0000_0078};
        regs[2] = '{ADDR_PERIOD, 32'hABCD_EF12, 32'h00CD_EF12};
        regs[3] = '{ADDR_MASK,   32'hFFFF_FFFF, 32'h0000_01FF};
        regs[4] = '{ADDR_MASK,   32'h0000_FE00, 32'h0000_0000};
        regs[5] = '{ADDR_CTRL,   32'h0000_0002, 32'h0000_0002};
        regs[6] = '{ADDR_DUTY,   32'h0000_0000, 32'h0000_0000};
        regs[7] = '{ADDR_PERIOD, 32'h0000_0005, 32'h0000_0005};

        leds[0] = '{9'h1A5, 9'h1A5};
        leds[1] = '{9'h000, 9'h000};
        leds[2] = '{9'h1FF, 9'h1FF};
        leds[3] = '{9'h05A, 9'h05A};
        leds[4] = '{9'h100, 9'h100};

        reset          = 1'b1;
        led_in         = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led_out", 32'(led_out), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_regs("rst");

        // Transparent 1-cycle register after reset
        prev = 9'h000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            led_in = leds[i].din;
            @(negedge clk);
            check($sformatf("pass_hold[%0d]", i), 32'(led_out), 32'(prev));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("pass_out[%0d]", i), 32'(led_out), 32'(leds[i].exp_out));
            prev = leds[i].exp_out;
        end

        // Register write/readback with unused bits dropped
        for (int i = 0; i < 8; i++) begin
            write_reg(regs[i].addr, regs[i].wdata);
            read_reg(regs[i].addr, rd);
            check($sformatf("reg_rd[%0d]", i), rd, regs[i].exp_rd);
        end

        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // PWM at DUTY=0x40: on for 64 of any 256 consecutive cycles
        led_in = 9'h1FF;
        write_reg(ADDR_CTRL, 32'h1);
        write_reg(ADDR_DUTY, 32'h40);
        repeat (3) @(posedge clk);
        on_cnt = 0;
        other_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (led_out == 9'h1FF)      on_cnt++;
            else if (led_out != 9'h000) other_cnt++;
        end
        check("pwm40_on_cycles", 32'(on_cnt), 32'd64);
        check("pwm40_bad_values", 32'(other_cnt), 32'd0);

        // DUTY=0: fully off
        write_reg(ADDR_DUTY, 32'h0);
        repeat (3) @(posedge clk);
        other_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (led_out != 9'h000) other_cnt++;
        end
        check("pwm00_not_off", 32'(other_cnt), 32'd0);

        // DUTY=0xFF: fully on
        write_reg(ADDR_DUTY, 32'hFF);
        repeat (3) @(posedge clk);
        other_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (led_out != 9'h1FF) other_cnt++;
        end
        check("pwmff_not_on", 32'(other_cnt), 32'd0);

        // Blink, half-period 10 on lanes 1:0
        write_reg(ADDR_CTRL, 32'h3);
        write_reg(ADDR_MASK, 32'h003);
        write_reg(ADDR_PERIOD, 32'd10);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_blink = (((k - 1) / 10) % 2 == 0) ? 9'h1FF : 9'h1FC;
            check($sformatf("blink[%0d]", k), 32'(led_out), 32'(exp_blink));
        end

        // PERIOD rewrite landing on the wrap edge restarts the half-period
        write_reg(ADDR_PERIOD, 32'd10);
        repeat (8) @(posedge clk);
        write_reg(ADDR_PERIOD, 32'd10);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_blink = (((k - 1) / 10) % 2 == 0) ? 9'h1FF : 9'h1FC;
            check($sformatf("restart[%0d]", k), 32'(led_out), 32'(exp_blink));
        end

        // PERIOD=0: no blinking
        write_reg(ADDR_PERIOD, 32'd0);
        other_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (led_out != 9'h1FF) other_cnt++;
        end
        check("period0_toggles", 32'(other_cnt), 32'd0);

        // Reset while phase=0
        write_reg(ADDR_PERIOD, 32'd10);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("pre_rst_dark", 32'(led_out), 32'h1FC);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_led_out", 32'(led_out), 32'h0);
        check_reset_regs("mid_rst");
        @(posedge clk);
        @(negedge clk);
        check("post_rst_track0", 32'(led_out), 32'h1FF);
        @(posedge clk); #1;
        led_in = 9'h05A;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_track1", 32'(led_out), 32'h05A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
